gray_cnt_decoder: RTL and testbench
===================================

# gray_cnt_decoder

Receive-side companion to the team's Gray-code counter. Samples a Gray-coded count word, decodes it to binary, and checks that each new sample is a legal single-step advance. Keeps an extended binary count by tracking wrap-arounds, and reports step, wrap and protocol-error events to the consuming logic on the same clock.

## Interface
Parameters:
- WIDTH, 4: Gray/binary count width; legal range WIDTH >= 2.
- EXT_WIDTH, 8: epoch (wrap counter) width; legal range EXT_WIDTH >= 1.

Ports:
- clk_i  input  1  single clock; all logic on posedge.
- rst_i  input  1  reset; asynchronous, active-low.
- valid_i  input  1  sample enable; gray_i is sampled on a posedge where valid_i=1.
- clr_i  input  1  synchronous clear; returns the block to INIT.
- gray_i  input  WIDTH  Gray-coded count from the producer.
- bin_o  output  WIDTH  registered binary decode of the last accepted sample.
- ext_cnt_o  output  EXT_WIDTH+WIDTH  {epoch, bin_o}.
- step_o  output  1  1-cycle pulse on a legal +1 advance.
- wrap_o  output  1  1-cycle pulse on the all-ones -> zero advance (step_o also 1).
- err_o  output  1  1-cycle pulse on an illegal transition.
- err_cnt_o  output  8  saturating count of err_o pulses.

## Operation
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- FSM has two states, INIT and TRACK. Reset and clr_i both enter INIT.
- INIT, valid_i=1:
  - Load bin_o = decode(gray_i) and set epoch = 0 as the baseline.
  - No pulses are generated.
  - Next state is TRACK.
- INIT, valid_i=0: hold.
- TRACK, valid_i=1: compare decode(gray_i) = B against the stored bin_o = P, using the Hamming distance between gray_i and the stored Gray value (encode(P) = P ^ (P>>1)).
  - Distance 0: no change, no pulses.
  - Distance 1 and B == P+1 mod 2^WIDTH:
    - bin_o <= B and step_o = 1.
    - If P is all-ones: wrap_o = 1 and epoch <= epoch+1, wrapping mod 2^EXT_WIDTH.
  - Distance 1 and B == P-1 mod 2^WIDTH (backward step):
    - err_o = 1; bin_o <= B (resync); epoch unchanged.
  - Distance > 1:
    - err_o = 1; bin_o <= B (resync); epoch unchanged; no step_o or wrap_o.
- TRACK, valid_i=0: hold all state; pulses are 0.
- err_cnt_o increments on each err_o and saturates at 255. Only reset or clr_i zero it.
- clr_i=1 has priority over valid_i. The sample in that cycle is discarded.
  - bin_o, epoch and err_cnt_o go to 0, pulses go to 0, state goes to INIT.
- The block is up-counting only; any backward movement is an error.

## Timing
- Reset (rst_i=0) takes effect asynchronously:
  - bin_o=0, ext_cnt_o=0, step_o=0, wrap_o=0, err_o=0, err_cnt_o=0, state INIT.
- Latency is one cycle. A sample accepted at edge N appears on bin_o, ext_cnt_o and the pulses after edge N.
- step_o, wrap_o and err_o are registered and high for exactly one cycle per accepted sample.
  - Back-to-back legal steps on consecutive cycles give step_o held high continuously.
- err_cnt_o updates in the same cycle that err_o is asserted.
- rst_i deasserted mid-stream: the first accepted sample after release is a baseline and never produces an error.
- gray_i is assumed synchronous to clk_i. Any CDC synchronizer sits upstream of this block.

## Test plan
- Reset, then feed WIDTH=4 Gray 0000 as baseline, then 0001,0011,0010.
  - bin_o goes 0,1,2,3.
  - step_o pulses three consecutive cycles.
  - err_o=0 throughout.
- Full wrap: baseline 1001 (bin 14), then 1000, then 0000.
  - bin_o goes 15, then 0.
  - wrap_o pulses with the 0 sample.
  - ext_cnt_o = 0x010.
- Multi-bit jump: baseline 0011 (bin 2), then 0110 (bin 4).
  - err_o pulses; step_o=0.
  - bin_o=4; err_cnt_o=1; epoch unchanged.
- Backward step: baseline 0011 (bin 2), then 0001 (bin 1).
  - err_o pulses; bin_o=1; err_cnt_o increments.
- Hold and enable gating:
  - Repeat the same Gray value with valid_i=1: no pulses.
  - Change gray_i with valid_i=0: bin_o unchanged.
- clr_i together with valid_i=1 carrying 0110, while err_cnt_o=5:
  - Next cycle bin_o=0, err_cnt_o=0, state INIT.
  - The following valid sample 0111 loads bin_o=5 with no pulse.
- Saturation: force 300 illegal jumps.
  - err_cnt_o stops at 255.

Source files
------------

// File: rtl/gray_cnt_decoder.sv
// gray_cnt_decoder: decodes a sampled Gray count, checks each new sample is a
// single +1 advance, and extends the count with an epoch of wrap-arounds.
module gray_cnt_decoder #(
    parameter int WIDTH     = 4,
    parameter int EXT_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic                       clr_i,
    input  logic [WIDTH-1:0]           gray_i,
    output logic [WIDTH-1:0]           bin_o,
    output logic [EXT_WIDTH+WIDTH-1:0] ext_cnt_o,
    output logic                       step_o,
    output logic                       wrap_o,
    output logic                       err_o,
    output logic [7:0]                 err_cnt_o
);
    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    logic [0:0]           state;
    logic [EXT_WIDTH-1:0] epoch;
    logic [WIDTH-1:0]     dec, nxt, diff;
    logic                 same, fwd, bad, last;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        g2b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) g2b[i] = g2b[i+1] ^ g[i];
    endfunction

    // A legal +1 advance always differs by one Gray bit, so only identity
    // and the forward successor are acceptable; everything else is an error.
    always_comb begin
        dec  = g2b(gray_i);
        nxt  = bin_o + 1'b1;
        diff = gray_i ^ (bin_o ^ (bin_o >> 1));
        same = diff == '0;
        fwd  = dec == nxt;
        bad  = !same && !fwd;
        last = &bin_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= INIT;
            bin_o     <= '0;
            epoch     <= '0;
            step_o    <= 1'b0;
            wrap_o    <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (clr_i) begin
            state     <= INIT;
            bin_o     <= '0;
            epoch     <= '0;
            step_o    <= 1'b0;
            wrap_o    <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            step_o <= 1'b0;
            wrap_o <= 1'b0;
            err_o  <= 1'b0;
            if (valid_i && state == INIT) begin
                state <= TRACK;
                bin_o <= dec;
                epoch <= '0;
            end else if (valid_i) begin
                step_o <= fwd;
                wrap_o <= fwd && last;
                err_o  <= bad;
                bin_o  <= dec;
                if (fwd && last) epoch <= epoch + 1'b1;
                if (bad && err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

    assign ext_cnt_o = {epoch, bin_o};
endmodule

// File: tb/tb_gray_cnt_decoder.sv
// tb_gray_cnt_decoder: directed scoreboard bench for gray_cnt_decoder (WIDTH=4, EXT_WIDTH=8).
module tb_gray_cnt_decoder;
    logic        clk = 1'b0, rst_i = 1'b0, valid_i = 1'b0, clr_i = 1'b0;
    logic [3:0]  gray_i = '0, bin_o;
    logic [11:0] ext_cnt_o;
    logic        step_o, wrap_o, err_o;
    logic [7:0]  err_cnt_o;
    int          errors = 0, checks = 0;

    typedef struct packed {
        logic [3:0]  b;
        logic [11:0] x;
        logic        s, w, e;
        logic [7:0]  n;
    } exp_t;
    exp_t q[$];

    gray_cnt_decoder #(.WIDTH(4), .EXT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .clr_i(clr_i), .gray_i(gray_i),
        .bin_o(bin_o), .ext_cnt_o(ext_cnt_o), .step_o(step_o), .wrap_o(wrap_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t c);
        chk("bin", 32'(bin_o), 32'(c.b));
        chk("ext", 32'(ext_cnt_o), 32'(c.x));
        chk("step", 32'(step_o), 32'(c.s));
        chk("wrap", 32'(wrap_o), 32'(c.w));
        chk("err", 32'(err_o), 32'(c.e));
        chk("err_cnt", 32'(err_cnt_o), 32'(c.n));
    endtask

    task automatic cyc(input logic v, input logic c, input logic [3:0] g,
                       input logic [3:0] b, input logic [11:0] x,
                       input logic s, input logic w, input logic e, input logic [7:0] n);
        exp_t cur;
        valid_i = v;
        clr_i   = c;
        gray_i  = g;
        q.push_back('{b: b, x: x, s: s, w: w, e: e, n: n});
        @(posedge clk);
        #1;
        cur = q.pop_front();
        check_all(cur);
    endtask

    initial begin
        #3;
        check_all('{b: 4'h0, x: 12'h000, s: 1'b0, w: 1'b0, e: 1'b0, n: 8'd0});
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        // basic counting from a zero baseline
        cyc(1, 0, 4'b0000, 4'd0, 12'h000, 0, 0, 0, 8'd0);
        cyc(1, 0, 4'b0001, 4'd1, 12'h001, 1, 0, 0, 8'd0);
        cyc(1, 0, 4'b0011, 4'd2, 12'h002, 1, 0, 0, 8'd0);
        cyc(1, 0, 4'b0010, 4'd3, 12'h003, 1, 0, 0, 8'd0);
        // full wrap into epoch 1
        cyc(0, 1, 4'b0000, 4'd0, 12'h000, 0, 0, 0, 8'd0);
        cyc(1, 0, 4'b1001, 4'd14, 12'h00e, 0, 0, 0, 8'd0);
        cyc(1, 0, 4'b1000, 4'd15, 12'h00f, 1, 0, 0, 8'd0);
        cyc(1, 0, 4'b0000, 4'd0, 12'h010, 1, 1, 0, 8'd0);
        cyc(1, 0, 4'b0001, 4'd1, 12'h011, 1, 0, 0, 8'd0);
        // multi-bit jump
        cyc(0, 1, 4'b0000, 4'd0, 12'h000, 0, 0, 0, 8'd0);
        cyc(1, 0, 4'b0011, 4'd2, 12'h002, 0, 0, 0, 8'd0);
        cyc(1, 0, 4'b0110, 4'd4, 12'h004, 0, 0, 1, 8'd1);
        // asynchronous reset mid-stream, then backward step
        #2;
        rst_i = 1'b0;
        #1;
        check_all('{b: 4'h0, x: 12'h000, s: 1'b0, w: 1'b0, e: 1'b0, n: 8'd0});
        @(negedge clk);
        rst_i = 1'b1;
        cyc(1, 0, 4'b0011, 4'd2, 12'h002, 0, 0, 0, 8'd0);
        cyc(1, 0, 4'b0001, 4'd1, 12'h001, 0, 0, 1, 8'd1);
        // hold and enable gating
        cyc(1, 0, 4'b0001, 4'd1, 12'h001, 0, 0, 0, 8'd1);
        cyc(0, 0, 4'b1111, 4'd1, 12'h001, 0, 0, 0, 8'd1);
        // top-bit flip is a single-bit change but not a +1 step
        cyc(1, 0, 4'b1001, 4'd14, 12'h00e, 0, 0, 1, 8'd2);
        cyc(1, 0, 4'b0001, 4'd1, 12'h001, 0, 0, 1, 8'd3);
        cyc(1, 0, 4'b0110, 4'd4, 12'h004, 0, 0, 1, 8'd4);
        cyc(1, 0, 4'b0011, 4'd2, 12'h002, 0, 0, 1, 8'd5);
        // clear wins over a valid sample; next sample is a fresh baseline
        cyc(1, 1, 4'b0110, 4'd0, 12'h000, 0, 0, 0, 8'd0);
        cyc(1, 0, 4'b0111, 4'd5, 12'h005, 0, 0, 0, 8'd0);
        // saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) cyc(1, 0, 4'b0000, 4'd0, 12'h000, 0, 0, 1, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            else            cyc(1, 0, 4'b0111, 4'd5, 12'h005, 0, 0, 1, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
        end
        cyc(1, 0, 4'b0101, 4'd6, 12'h006, 1, 0, 0, 8'd255);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
